// File: rtl/bs_job_dispatcher.sv
// bs_job_dispatcher: sequences option-pricing jobs into the Black-Scholes core.
// A small FIFO buffers tagged requests. Each job is parameter-checked and then
// issued to the core with a one-cycle start pulse. The dispatcher waits for the
// core's done (edge detected) or a timeout, and returns the result in order.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   in_*               request valid/ready, tag, Q16.16 parameters, option type
//   core_start/core_*  start pulse and parameters driven to the core
//   core_done/price    completion and price returned by the core
//   out_*              result valid/ready, tag, price (0 on error), error flag
//   busy               FSM not idle or FIFO non-empty
module bs_job_dispatcher #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 1000
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [WIDTH-1:0] in_S0,
  input  logic [WIDTH-1:0] in_K,
  input  logic [WIDTH-1:0] in_T,
  input  logic [WIDTH-1:0] in_sigma,
  input  logic [WIDTH-1:0] in_r,
  input  logic             in_otype,
  output logic             core_start,
  output logic [WIDTH-1:0] core_S0,
  output logic [WIDTH-1:0] core_K,
  output logic [WIDTH-1:0] core_T,
  output logic [WIDTH-1:0] core_sigma,
  output logic [WIDTH-1:0] core_r,
  output logic             core_otype,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_price,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [WIDTH-1:0] out_price,
  output logic             out_err,
  output logic             busy
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef struct packed {
    logic [WIDTH-1:0] s0, k, t, sigma, r;
    logic             otype;
  } param_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    param_t           p;
  } job_t;

  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, OUT} state_t;

  job_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           state_q, state_d;
  job_t             job_q, job_d;
  logic [TO_W-1:0]  tmo_q, tmo_d;
  logic             done_prev_q;
  logic             start_q, start_d;
  param_t           core_q, core_d;
  logic             valid_q, valid_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WIDTH-1:0] price_q, price_d;
  logic             err_q, err_d;

  logic full, push, pop, done_rise, bad;
  job_t in_job;

  assign full      = (cnt_q == CNT_W'(DEPTH));
  // Gated by reset so every output reads 0 while reset is held.
  assign in_ready  = !full && !reset;
  assign push      = in_valid && in_ready;
  assign pop       = (state_q == IDLE) && (cnt_q != '0);
  // Edge detect so a level-held done is not mistaken for the next job's done.
  assign done_rise = core_done && !done_prev_q;
  assign bad       = ($signed(job_q.p.s0) <= 0) || ($signed(job_q.p.k) <= 0) ||
                     ($signed(job_q.p.t) <= 0)  || ($signed(job_q.p.sigma) <= 0);
  assign in_job    = '{tag: in_tag,
                       p: '{s0: in_S0, k: in_K, t: in_T, sigma: in_sigma, r: in_r, otype: in_otype}};

  // FIFO storage needs no reset; validity is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_job;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    state_d  = state_q;
    job_d    = job_q;
    tmo_d    = tmo_q;
    start_d  = 1'b0;
    core_d   = core_q;
    valid_d  = valid_q;
    tag_d    = tag_q;
    price_d  = price_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (pop) begin
        job_d   = mem_q[rd_ptr_q];
        state_d = CHECK;
      end
      CHECK: if (bad) begin
        state_d = OUT;
        valid_d = 1'b1;
        tag_d   = job_q.tag;
        price_d = '0;
        err_d   = 1'b1;
      end else begin
        state_d = ISSUE;
        start_d = 1'b1;
        core_d  = job_q.p;
      end
      ISSUE: begin
        state_d = WAIT;
        tmo_d   = '0;
      end
      WAIT: begin
        if (done_rise) begin
          state_d = OUT;
          valid_d = 1'b1;
          tag_d   = job_q.tag;
          price_d = core_price;
          err_d   = 1'b0;
        end else if (tmo_q == TO_W'(TIMEOUT - 1)) begin
          state_d = OUT;
          valid_d = 1'b1;
          tag_d   = job_q.tag;
          price_d = '0;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TO_W'(1);
        end
      end
      OUT: if (out_ready) begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      state_q     <= IDLE;
      job_q       <= '0;
      tmo_q       <= '0;
      done_prev_q <= 1'b0;
      start_q     <= 1'b0;
      core_q      <= '0;
      valid_q     <= 1'b0;
      tag_q       <= '0;
      price_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      job_q       <= job_d;
      tmo_q       <= tmo_d;
      done_prev_q <= core_done;
      start_q     <= start_d;
      core_q      <= core_d;
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      price_q     <= price_d;
      err_q       <= err_d;
    end
  end

  assign core_start = start_q;
  assign core_S0    = core_q.s0;
  assign core_K     = core_q.k;
  assign core_T     = core_q.t;
  assign core_sigma = core_q.sigma;
  assign core_r     = core_q.r;
  assign core_otype = core_q.otype;
  assign out_valid  = valid_q;
  assign out_tag    = tag_q;
  assign out_price  = price_q;
  assign out_err    = err_q;
  assign busy       = (state_q != IDLE) || (cnt_q != '0);
endmodule

// File: tb/tb_bs_job_dispatcher.sv
// Directed bench for bs_job_dispatcher with a stub pricing core.
module tb_bs_job_dispatcher;
  logic        clk = 0, reset = 1;
  logic        in_valid = 0, in_ready, in_otype = 0;
  logic [3:0]  in_tag = 0;
  logic [31:0] in_S0 = 0, in_K = 0, in_T = 0, in_sigma = 0, in_r = 0;
  logic        core_start, core_otype, core_done;
  logic [31:0] core_S0, core_K, core_T, core_sigma, core_r, core_price;
  logic        out_valid, out_ready = 1, out_err, busy;
  logic [3:0]  out_tag;
  logic [31:0] out_price;

  int n_chk = 0, n_err = 0;
  int n_start = 0, n_overlap = 0;
  int stub_cnt;
  logic        stub_en = 1, fixed_en = 0;
  logic [31:0] fixed_price = 0;
  int          stub_delay = 20;

  typedef struct packed { logic [3:0] tag; logic [31:0] price; logic err; } res_t;
  res_t res_q[$];

  always #5 clk = ~clk;

  bs_job_dispatcher #(.WIDTH(32), .DEPTH(4), .TAG_W(4), .TIMEOUT(50)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
    .in_S0(in_S0), .in_K(in_K), .in_T(in_T), .in_sigma(in_sigma), .in_r(in_r),
    .in_otype(in_otype),
    .core_start(core_start), .core_S0(core_S0), .core_K(core_K), .core_T(core_T),
    .core_sigma(core_sigma), .core_r(core_r), .core_otype(core_otype),
    .core_done(core_done), .core_price(core_price),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_price(out_price), .out_err(out_err), .busy(busy)
  );

  // Stub core: one-cycle done pulse stub_delay cycles after start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stub_cnt   <= 0;
      core_done  <= 1'b0;
      core_price <= '0;
    end else begin
      core_done <= 1'b0;
      if (core_start) begin
        if (stub_en) stub_cnt <= stub_delay;
      end else if (stub_cnt > 0) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1) begin
          core_done  <= 1'b1;
          core_price <= fixed_en ? fixed_price : core_S0 + core_K;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (core_start) begin
      n_start <= n_start + 1;
      if (stub_cnt != 0) n_overlap <= n_overlap + 1;
    end
  end

  always @(negedge clk)
    if (!reset && out_valid && out_ready) res_q.push_back('{out_tag, out_price, out_err});

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [3:0] tg, input logic [31:0] s, k, t, sg, r, input logic ot);
    int n = 0;
    @(negedge clk);
    in_valid = 1; in_tag = tg; in_S0 = s; in_K = k; in_T = t; in_sigma = sg; in_r = r; in_otype = ot;
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (!in_ready) chk("push_timeout", 0, 1);
    tick();
    in_valid = 0;
  endtask

  task automatic wait_res(input int cnt);
    int n = 0;
    while (res_q.size() < cnt && n < 600) begin tick(); n++; end
    chk("res_count", res_q.size(), cnt);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int st0, n;
    logic [31:0] s;
    logic [3:0]  h_tag;
    logic [31:0] h_price;
    logic        h_err, stable;

    // Reset state
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk); reset = 0; #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy_rel", busy, 0);

    // Valid call, fixed price
    fixed_en = 1; fixed_price = 32'h00047AE1; res_q.delete(); st0 = n_start;
    push(3, 32'h00140000, 32'h00100000, 32'h00010000, 32'h00004CCD, 32'h00000666, 0);
    tick();
    chk("v_start_early", core_start, 0);
    tick();
    chk("v_start", core_start, 1);
    chk("v_S0", core_S0, 32'h00140000);
    chk("v_K", core_K, 32'h00100000);
    chk("v_T", core_T, 32'h00010000);
    chk("v_sigma", core_sigma, 32'h00004CCD);
    chk("v_r", core_r, 32'h00000666);
    chk("v_otype", core_otype, 0);
    tick();
    chk("v_start_pulse", core_start, 0);
    wait_res(1);
    if (res_q.size() >= 1) begin
      chk("v_tag", res_q[0].tag, 3);
      chk("v_price", res_q[0].price, 32'h00047AE1);
      chk("v_err", res_q[0].err, 0);
    end
    chk("v_nstart", n_start - st0, 1);

    // Invalid request (T = 0)
    fixed_en = 0; res_q.delete(); st0 = n_start;
    push(5, 32'h00140000, 32'h00100000, 32'h00000000, 32'h00004CCD, 32'h00000666, 1);
    tick(); tick();
    chk("inv_valid", out_valid, 1);
    chk("inv_tag", out_tag, 5);
    chk("inv_price", out_price, 0);
    chk("inv_err", out_err, 1);
    repeat (5) tick();
    chk("inv_nstart", n_start - st0, 0);

    // Back-to-back: job 0 is popped immediately, so 1..4 fill the 4-deep FIFO
    res_q.delete(); st0 = n_start;
    for (int i = 0; i < 5; i++) begin
      s = 32'h00010000 * (i + 1);
      push(4'(i), s, 32'h00008000, 32'h00010000,
           (i == 2) ? 32'hFFFF0000 : 32'h00004CCD, 32'hFFFFF000, i[0]);
    end
    chk("b2b_full", in_ready, 0);
    wait_res(5);
    if (res_q.size() >= 5)
      for (int i = 0; i < 5; i++) begin
        chk("b2b_tag", res_q[i].tag, i);
        chk("b2b_err", res_q[i].err, (i == 2));
        chk("b2b_price", res_q[i].price, (i == 2) ? 0 : 32'h00010000 * (i + 1) + 32'h00008000);
      end
    chk("b2b_nstart", n_start - st0, 4);
    chk("b2b_overlap", n_overlap, 0);

    // Output backpressure
    out_ready = 0; res_q.delete(); st0 = n_start;
    push(7, 32'h00020000, 32'h00010000, 32'h00010000, 32'h00004CCD, 0, 0);
    push(8, 32'h00030000, 32'h00010000, 32'h00010000, 32'h00004CCD, 0, 1);
    n = 0;
    while (!out_valid && n < 200) begin tick(); n++; end
    chk("bp_valid", out_valid, 1);
    h_tag = out_tag; h_price = out_price; h_err = out_err; stable = 1;
    chk("bp_tag", h_tag, 7);
    chk("bp_price", h_price, 32'h00030000);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!out_valid || out_tag !== h_tag || out_price !== h_price || out_err !== h_err) stable = 0;
    end
    chk("bp_stable", stable, 1);
    chk("bp_nstart", n_start - st0, 1);
    out_ready = 1;
    wait_res(2);
    if (res_q.size() >= 2) begin
      chk("bp_order0", res_q[0].tag, 7);
      chk("bp_order1", res_q[1].tag, 8);
      chk("bp_price1", res_q[1].price, 32'h00040000);
    end

    // Timeout, then next job issues normally
    stub_en = 0; res_q.delete();
    push(9, 32'h00020000, 32'h00010000, 32'h00010000, 32'h00004CCD, 0, 0);
    push(10, 32'h00050000, 32'h00010000, 32'h00010000, 32'h00004CCD, 0, 0);
    n = 0;
    while (!core_start && n < 50) begin tick(); n++; end
    chk("to_start", core_start, 1);
    n = 0;
    while (!out_valid && n < 200) begin tick(); n++; end
    stub_en = 1;
    chk("to_latency", n, 51);
    chk("to_tag", out_tag, 9);
    chk("to_err", out_err, 1);
    chk("to_price", out_price, 0);
    wait_res(2);
    if (res_q.size() >= 2) begin
      chk("to_next_tag", res_q[1].tag, 10);
      chk("to_next_err", res_q[1].err, 0);
      chk("to_next_price", res_q[1].price, 32'h00060000);
    end

    // Reset mid-WAIT with two jobs queued
    res_q.delete(); st0 = n_start;
    push(11, 32'h00020000, 32'h00010000, 32'h00010000, 32'h00004CCD, 0, 0);
    push(12, 32'h00020000, 32'h00010000, 32'h00010000, 32'h00004CCD, 0, 0);
    push(13, 32'h00020000, 32'h00010000, 32'h00010000, 32'h00004CCD, 0, 0);
    repeat (5) tick();
    chk("mr_busy_pre", busy, 1);
    #2 reset = 1; #1;
    chk("mr_out_valid", out_valid, 0);
    chk("mr_core_start", core_start, 0);
    chk("mr_core_S0", core_S0, 0);
    chk("mr_busy", busy, 0);
    chk("mr_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    reset = 0; #1;
    chk("mr_in_ready_rel", in_ready, 1);
    chk("mr_busy_rel", busy, 0);
    repeat (60) tick();
    chk("mr_no_stale", res_q.size(), 0);
    chk("mr_nstart", n_start - st0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
